// File: rtl/cond_flag_unit.sv
// EX-stage condition evaluation: NZCV flag register, write-enable gating,
// MEM-stage enable pipeline registers and a saturating annulled-instruction counter.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       flags,
  output logic             pc_src_m,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [CNT_W-1:0] annul_cnt
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0]       r_flags;
  logic             r_pcSrcM;
  logic             r_regWriteM;
  logic             r_memWriteM;
  logic [CNT_W-1:0] r_annulCnt;

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_condPass;
  logic w_go;
  logic w_pcSrc;
  logic w_regWrite;
  logic w_memWrite;
  logic w_annul;
  logic w_cntFull;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition is judged against the registered flags only, never the ALU's fresh result.
  always_comb begin
    w_condPass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: w_condPass = w_z;
      COND_NE: w_condPass = ~w_z;
      COND_CS: w_condPass = w_c;
      COND_CC: w_condPass = ~w_c;
      COND_MI: w_condPass = w_n;
      COND_PL: w_condPass = ~w_n;
      COND_VS: w_condPass = w_v;
      COND_VC: w_condPass = ~w_v;
      COND_HI: w_condPass = w_c & ~w_z;
      COND_LS: w_condPass = ~w_c | w_z;
      COND_GE: w_condPass = (w_n == w_v);
      COND_LT: w_condPass = (w_n != w_v);
      COND_GT: w_condPass = ~w_z & (w_n == w_v);
      COND_LE: w_condPass = w_z | (w_n != w_v);
      COND_AL: w_condPass = 1'b1;
      COND_NV: w_condPass = 1'b1;
      default: w_condPass = 1'b0;
    endcase
  end

  assign w_go       = valid_i & ~flush & w_condPass;
  assign w_pcSrc    = w_go & pcs;
  assign w_regWrite = w_go & reg_w & ~no_write;
  assign w_memWrite = w_go & mem_w;
  assign w_annul    = valid_i & ~flush & ~w_condPass;
  assign w_cntFull  = &r_annulCnt;

  // N,Z and C,V halves update independently; a half not selected keeps its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= FLAG_RST;
    end else if (en && w_go) begin
      if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
      if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcSrcM    <= 1'b0;
      r_regWriteM <= 1'b0;
      r_memWriteM <= 1'b0;
    end else if (en) begin
      r_pcSrcM    <= w_pcSrc;
      r_regWriteM <= w_regWrite;
      r_memWriteM <= w_memWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_annulCnt <= '0;
    end else if (en && w_annul && !w_cntFull) begin
      r_annulCnt <= r_annulCnt + CNT_W'(1);
    end
  end

  assign cond_ex     = w_condPass;
  assign pc_src      = w_pcSrc;
  assign reg_write   = w_regWrite;
  assign mem_write   = w_memWrite;
  assign flags       = r_flags;
  assign pc_src_m    = r_pcSrcM;
  assign reg_write_m = r_regWriteM;
  assign mem_write_m = r_memWriteM;
  assign annul_cnt   = r_annulCnt;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: two instances (default widths, and CNT_W=2 with a
// non-zero reset flag value) driven by shared stimulus and checked against a model.
module tb_cond_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic       valid_i;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;

  logic        condExA, pcSrcA, regWriteA, memWriteA, pcSrcMA, regWriteMA, memWriteMA;
  logic [3:0]  flagsA;
  logic [15:0] annulCntA;
  logic        condExB, pcSrcB, regWriteB, memWriteB, pcSrcMB, regWriteMB, memWriteMB;
  logic [3:0]  flagsB;
  logic [1:0]  annulCntB;

  int checkCount;
  int failCount;

  logic [3:0] mFlags [2];
  int         mCnt   [2];
  bit         mPcM   [2];
  bit         mRegM  [2];
  bit         mMemM  [2];

  localparam logic [3:0] RST_A = 4'b0000;
  localparam logic [3:0] RST_B = 4'b1010;

  cond_flag_unit dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs),
    .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .cond_ex(condExA), .pc_src(pcSrcA), .reg_write(regWriteA), .mem_write(memWriteA),
    .flags(flagsA), .pc_src_m(pcSrcMA), .reg_write_m(regWriteMA),
    .mem_write_m(memWriteMA), .annul_cnt(annulCntA)
  );

  cond_flag_unit #(.FLAG_RST(RST_B), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs),
    .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .cond_ex(condExB), .pc_src(pcSrcB), .reg_write(regWriteB), .mem_write(memWriteB),
    .flags(flagsB), .pc_src_m(pcSrcMB), .reg_write_m(regWriteMB),
    .mem_write_m(memWriteMB), .annul_cnt(annulCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition check: odd codes invert the even code's test, AL/NV always pass.
  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic int cntMax(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Checks combinational outputs of both instances, clocks one edge, updates the
  // model and then checks the registered outputs.
  task automatic applyStimulus;
    bit pass, go;
    bit obsCond, obsPc, obsReg, obsMem;
    logic [3:0] nFlags [2];
    int nCnt [2];
    bit nPc [2], nReg [2], nMem [2];
    #2;
    for (int k = 0; k < 2; k++) begin
      pass = condHolds(cond, mFlags[k]);
      go = valid_i && !flush && pass;
      obsCond = (k == 0) ? condExA   : condExB;
      obsPc   = (k == 0) ? pcSrcA    : pcSrcB;
      obsReg  = (k == 0) ? regWriteA : regWriteB;
      obsMem  = (k == 0) ? memWriteA : memWriteB;
      checkOutput($sformatf("cond_ex[%0d]", k), 32'(obsCond), 32'(pass));
      checkOutput($sformatf("pc_src[%0d]", k), 32'(obsPc), 32'(go && pcs));
      checkOutput($sformatf("reg_write[%0d]", k), 32'(obsReg), 32'(go && reg_w && !no_write));
      checkOutput($sformatf("mem_write[%0d]", k), 32'(obsMem), 32'(go && mem_w));
      nFlags[k] = mFlags[k]; nCnt[k] = mCnt[k];
      nPc[k] = mPcM[k]; nReg[k] = mRegM[k]; nMem[k] = mMemM[k];
      if (!rst_n) begin
        nFlags[k] = (k == 0) ? RST_A : RST_B;
        nCnt[k] = 0; nPc[k] = 0; nReg[k] = 0; nMem[k] = 0;
      end else if (en) begin
        if (go && flag_w[1]) nFlags[k][3:2] = alu_flags[3:2];
        if (go && flag_w[0]) nFlags[k][1:0] = alu_flags[1:0];
        nPc[k]  = go && pcs;
        nReg[k] = go && reg_w && !no_write;
        nMem[k] = go && mem_w;
        if (valid_i && !flush && !pass && mCnt[k] < cntMax(k)) nCnt[k] = mCnt[k] + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mFlags[k] = nFlags[k]; mCnt[k] = nCnt[k];
      mPcM[k] = nPc[k]; mRegM[k] = nReg[k]; mMemM[k] = nMem[k];
    end
    checkOutput("flags[0]", 32'(flagsA), 32'(mFlags[0]));
    checkOutput("flags[1]", 32'(flagsB), 32'(mFlags[1]));
    checkOutput("annul_cnt[0]", 32'(annulCntA), 32'(mCnt[0]));
    checkOutput("annul_cnt[1]", 32'(annulCntB), 32'(mCnt[1]));
    checkOutput("pc_src_m[0]", 32'(pcSrcMA), 32'(mPcM[0]));
    checkOutput("pc_src_m[1]", 32'(pcSrcMB), 32'(mPcM[1]));
    checkOutput("reg_write_m[0]", 32'(regWriteMA), 32'(mRegM[0]));
    checkOutput("reg_write_m[1]", 32'(regWriteMB), 32'(mRegM[1]));
    checkOutput("mem_write_m[0]", 32'(memWriteMA), 32'(mMemM[0]));
    checkOutput("mem_write_m[1]", 32'(memWriteMB), 32'(mMemM[1]));
  endtask

  task automatic setInputs(input bit v, input bit f, input logic [3:0] c, input logic [3:0] af,
                           input logic [1:0] fw, input bit p, input bit r, input bit m, input bit nw);
    valid_i = v; flush = f; cond = c; alu_flags = af; flag_w = fw;
    pcs = p; reg_w = r; mem_w = m; no_write = nw;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    for (int k = 0; k < 2; k++) begin
      mFlags[k] = 4'b0000; mCnt[k] = 0; mPcM[k] = 0; mRegM[k] = 0; mMemM[k] = 0;
    end
    rst_n = 1'b0; en = 1'b1;
    setInputs(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);

    // Reset: one edge with rst_n low.
    applyStimulus();
    checkOutput("reset flags A", 32'(flagsA), 32'h0);
    checkOutput("reset flags B", 32'(flagsB), 32'ha);
    checkOutput("reset cnt A", 32'(annulCntA), 32'h0);
    #1;
    checkOutput("reset EQ cond_ex", 32'(condExA), 32'h0);
    rst_n = 1'b1;

    // CMP-style instruction then a dependent EQ instruction.
    setInputs(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
    #1;
    checkOutput("cmp reg_write", 32'(regWriteA), 32'h0);
    applyStimulus();
    checkOutput("cmp flags", 32'(flagsA), 32'h4);
    setInputs(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
    applyStimulus();
    checkOutput("eq reg_write_m", 32'(regWriteMA), 32'h1);

    // N=1,V=0: GE fails and is counted, LT passes.
    setInputs(1, 0, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0);
    applyStimulus();
    setInputs(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
    applyStimulus();
    checkOutput("GE annul cnt", 32'(annulCntA), 32'h1);
    setInputs(1, 0, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0);
    #1;
    checkOutput("LT cond_ex", 32'(condExA), 32'h1);
    applyStimulus();

    // Partial flag update keeps C,V.
    setInputs(1, 0, 4'b1110, 4'b0001, 2'b11, 0, 0, 0, 0);
    applyStimulus();
    setInputs(1, 0, 4'b1110, 4'b0011, 2'b10, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("half update flags", 32'(flagsA), 32'h1);

    // Flush kills writes and flag update.
    setInputs(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
    applyStimulus();
    checkOutput("flush mem_write_m", 32'(memWriteMA), 32'h0);
    checkOutput("flush flags", 32'(flagsA), 32'h1);

    // Saturation of the 2-bit counter after reset, then a stall.
    rst_n = 1'b0;
    setInputs(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
    applyStimulus();
    rst_n = 1'b1;
    setInputs(1, 0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("sat cnt step %0d", i), 32'(annulCntB), 32'((i < 3) ? i + 1 : 3));
    end
    en = 1'b0;
    setInputs(1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
    applyStimulus();
    checkOutput("stall cnt", 32'(annulCntB), 32'h3);
    checkOutput("stall flags", 32'(flagsB), 32'ha);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) != 0);
      setInputs($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
